// File: rtl/ldm_ctrl_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_ctrl_pkg;

  // Architectural register count (width of the register list)
  localparam int LDM_NREG       = 16;
  // Byte stride between consecutive transfers
  localparam int LDM_WORD_BYTES = 4;

  // Sequencer states; WBACK is only reachable with base write-back compiled in
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    WBACK = 2'd2
  } state_t;

  // Addressing mode encoded as {P,U}
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } mode_t;

  // Sign-extend an 8-bit offset intermediate to a 32-bit byte offset
  function automatic logic [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

endpackage

// File: rtl/ldm_ctrl_ffs16.sv
// Lowest-set-bit finder over a 16-bit vector.
// idx is the position of the lowest set bit; found is 0 when the vector is empty.
module ldm_ctrl_ffs16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        found
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx   = 4'd0;
    found = 1'b0;
    for (int k = 15; k >= 0; k--) begin
      if (vec[k]) begin
        idx   = 4'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_ctrl.sv
// LDM/STM block-transfer sequencer for the EX stage.
// Walks the register list lowest register first, one memory beat per set bit,
// and holds the front of the pipeline until the sequence completes.
// Optional feature: define LDM_BASE_WB_EN to append a base write-back beat
// (WBACK) when the W bit is set; without it i_wb is ignored.
module ldm_ctrl
  import ldm_ctrl_pkg::*;
#(
  parameter int NREG       = LDM_NREG,
  parameter int WORD_BYTES = LDM_WORD_BYTES
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [NREG-1:0] i_reg_list,
  input  logic            i_is_load,
  input  logic            i_pre,
  input  logic            i_up,
  input  logic            i_wb,
  input  logic [3:0]      i_base_code,
  input  logic            i_stall,
  input  logic [31:0]     i_rf_rd_data,
  output logic [3:0]      o_rf_rd_code,
  output logic            o_busy,
  output logic [31:0]     o_ldm_offset,
  output logic            o_ldm_mem_vld,
  output logic [3:0]      o_ldm_reg_code,
  output logic [31:0]     o_ldm_reg,
  output logic            o_ldm_wb_vld,
  output logic            o_done
);

  localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);

  // Sequencer state
  state_t          state_reg;
  logic [NREG-1:0] pending_reg;
  logic [3:0]      idx_reg;
  logic [4:0]      n_reg;
  mode_t           mode_reg;
  logic            is_load_reg;
  logic [3:0]      base_reg;

  // Current-beat decode
  logic [3:0]      cur_code;
  logic            cur_found;
  logic [NREG-1:0] pending_next;
  logic            last_beat;
  logic [4:0]      list_count;
  logic            wb_follow;

  // Offset arithmetic, all in an 8-bit intermediate (range is -64..+64)
  logic [7:0]      w8;
  logic [7:0]      iw8;
  logic [7:0]      wn8;
  logic [7:0]      beat_off8;
  logic [7:0]      wb_off8;

`ifdef LDM_BASE_WB_EN
  logic            wb_reg;
  assign wb_follow = wb_reg;
`else
  // W bit has no effect in this build; base write-back belongs to other logic
  logic            unused_wb;
  assign unused_wb = i_wb;
  assign wb_follow = 1'b0;
`endif

  ldm_ctrl_ffs16 u_ffs (
    .vec   (pending_reg),
    .idx   (cur_code),
    .found (cur_found)
  );

  assign pending_next = pending_reg & ~(ONE_HOT0 << cur_code);
  assign last_beat    = cur_found && (pending_next == '0);

  // Number of transfers in the incoming list
  always_comb begin
    list_count = 5'd0;
    for (int k = 0; k < NREG; k++) begin
      list_count = list_count + 5'(i_reg_list[k]);
    end
  end

  assign w8  = 8'(WORD_BYTES);
  assign iw8 = w8 * {4'd0, idx_reg};
  assign wn8 = w8 * {3'd0, n_reg};

  // Per-beat offset: lowest register always lands on the lowest address
  always_comb begin
    beat_off8 = 8'd0;
    case (mode_reg)
      MODE_IA: beat_off8 = iw8;
      MODE_IB: beat_off8 = iw8 + w8;
      MODE_DA: beat_off8 = iw8 + w8 - wn8;
      MODE_DB: beat_off8 = iw8 - wn8;
      default: beat_off8 = 8'd0;
    endcase
  end

  // Base write-back moves the base by the whole block in the U direction
  assign wb_off8 = mode_reg[0] ? wn8 : (8'd0 - wn8);

  // Store data is a straight pass-through of the register-file read port
  assign o_ldm_reg = i_rf_rd_data;

  // Output decode from registered state; busy is raised in the accept cycle too
  always_comb begin
    o_busy         = 1'b0;
    o_ldm_offset   = 32'd0;
    o_ldm_mem_vld  = 1'b0;
    o_ldm_reg_code = 4'd0;
    o_rf_rd_code   = 4'd0;
    o_ldm_wb_vld   = 1'b0;
    o_done         = 1'b0;
    case (state_reg)
      IDLE: begin
        o_busy = i_start & i_rst_n;
      end
      XFER: begin
        o_busy = 1'b1;
        if (cur_found) begin
          o_ldm_mem_vld  = 1'b1;
          o_ldm_reg_code = cur_code;
          o_rf_rd_code   = cur_code;
          o_ldm_wb_vld   = is_load_reg;
          o_ldm_offset   = sext8(beat_off8);
          o_done         = ~i_stall & last_beat & ~wb_follow;
        end else begin
          // Empty list: a single no-op cycle that only signals completion
          o_done = ~i_stall;
        end
      end
      WBACK: begin
        o_busy         = 1'b1;
        o_ldm_wb_vld   = 1'b1;
        o_ldm_reg_code = base_reg;
        o_ldm_offset   = sext8(wb_off8);
        o_done         = ~i_stall;
      end
      default: ;
    endcase
  end

  // Sequencer: latch the request, step one register per unstalled cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      idx_reg     <= 4'd0;
      n_reg       <= 5'd0;
      mode_reg    <= MODE_DA;
      is_load_reg <= 1'b0;
      base_reg    <= 4'd0;
`ifdef LDM_BASE_WB_EN
      wb_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            pending_reg <= i_reg_list;
            idx_reg     <= 4'd0;
            n_reg       <= list_count;
            mode_reg    <= mode_t'({i_pre, i_up});
            is_load_reg <= i_is_load;
            base_reg    <= i_base_code;
`ifdef LDM_BASE_WB_EN
            wb_reg      <= i_wb;
`endif
            state_reg   <= XFER;
          end
        end
        XFER: begin
          if (!i_stall) begin
            if (!cur_found) begin
              state_reg <= IDLE;
            end else begin
              pending_reg <= pending_next;
              idx_reg     <= idx_reg + 4'd1;
              if (last_beat) begin
                state_reg <= wb_follow ? WBACK : IDLE;
              end
            end
          end
        end
        WBACK: begin
          if (!i_stall) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_ctrl.sv
// Bench for ldm_ctrl: directed sequences, expected beats queued by the
// stimulus and consumed by a monitor whenever the DUT presents a beat.
module tb_ldm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] reg_list;
  logic        is_load;
  logic        pre;
  logic        up;
  logic        wb;
  logic [3:0]  base_code;
  logic        stall;
  logic [31:0] rf_rd_data;
  logic [3:0]  rf_rd_code;
  logic        busy;
  logic [31:0] ldm_offset;
  logic        ldm_mem_vld;
  logic [3:0]  ldm_reg_code;
  logic [31:0] ldm_reg;
  logic        ldm_wb_vld;
  logic        done;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] off;
    logic        mem;
    logic        wbv;
    logic        dn;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests    = 0;
  int    n_fail     = 0;
  int    busy_total = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_data(input logic [3:0] c);
    return {16'hC0DE, 4'h0, c, 4'h0, c};
  endfunction

  always_comb rf_rd_data = rf_data(rf_rd_code);

  ldm_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_reg_list     (reg_list),
    .i_is_load      (is_load),
    .i_pre          (pre),
    .i_up           (up),
    .i_wb           (wb),
    .i_base_code    (base_code),
    .i_stall        (stall),
    .i_rf_rd_data   (rf_rd_data),
    .o_rf_rd_code   (rf_rd_code),
    .o_busy         (busy),
    .o_ldm_offset   (ldm_offset),
    .o_ldm_mem_vld  (ldm_mem_vld),
    .o_ldm_reg_code (ldm_reg_code),
    .o_ldm_reg      (ldm_reg),
    .o_ldm_wb_vld   (ldm_wb_vld),
    .o_done         (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic [31:0] o, input logic m,
                      input logic w, input logic d);
    beat_t b;
    b.code = c; b.off = o; b.mem = m; b.wbv = w; b.dn = d;
    exp_q.push_back(b);
  endtask

  task automatic monitor_loop();
    beat_t e;
    logic  exp_done;
    logic  bad;
    forever begin
      @(negedge clk);
      if (busy) busy_total++;
      if (ldm_mem_vld || ldm_wb_vld || done) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: code=%0d off=0x%08h mem=%0b wb=%0b done=%0b, none expected",
                   ldm_reg_code, ldm_offset, ldm_mem_vld, ldm_wb_vld, done);
        end else begin
          e        = exp_q[0];
          exp_done = e.dn & ~stall;
          bad = (ldm_reg_code !== e.code) || (ldm_offset !== e.off) ||
                (ldm_mem_vld !== e.mem) || (ldm_wb_vld !== e.wbv) || (done !== exp_done);
          if (e.mem)
            bad = bad || (rf_rd_code !== e.code) || (ldm_reg !== rf_data(e.code));
          if (bad) begin
            n_fail++;
            $display("FAIL beat: got code=%0d rd=%0d off=0x%08h mem=%0b wb=%0b done=%0b data=0x%08h; expected code=%0d off=0x%08h mem=%0b wb=%0b done=%0b data=0x%08h",
                     ldm_reg_code, rf_rd_code, ldm_offset, ldm_mem_vld, ldm_wb_vld, done, ldm_reg,
                     e.code, e.off, e.mem, e.wbv, exp_done, rf_data(e.code));
          end else begin
            $display("[TB] beat code=%0d off=0x%08h mem=%0b wb=%0b done=%0b stall=%0b",
                     ldm_reg_code, ldm_offset, ldm_mem_vld, ldm_wb_vld, done, stall);
          end
          if (!stall) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  // Issue one request (expected beats must already be queued) and wait for done
  task automatic run_seq(input string name, input logic [15:0] list, input logic ld,
                         input logic p, input logic u, input logic w, input logic [3:0] base,
                         input int stall_n, input logic extra_start, input int exp_busy);
    int   busy0;
    int   c;
    logic got;
    @(posedge clk); #1;
    busy0     = busy_total;
    start     = 1'b1;
    reg_list  = list;
    is_load   = ld;
    pre       = p;
    up        = u;
    wb        = w;
    base_code = base;
    stall     = (stall_n > 0);
    @(negedge clk);
    chk({name, "_busy_accept"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    // Optionally keep start high with a different list: must be ignored
    start = extra_start;
    if (extra_start) reg_list = 16'hFFFF;
    c   = 1;
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      @(posedge clk); #1;
      c++;
      if (c == 2) start = 1'b0;
      if (c == stall_n + 1) stall = 1'b0;
    end
    start = 1'b0;
    stall = 1'b0;
    chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
    @(negedge clk);
    chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({name, "_busy_cycles"}, 32'(busy_total - busy0), 32'(exp_busy));
    chk({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    rst_n     = 1'b0;
    start     = 1'b0;
    reg_list  = 16'h0000;
    is_load   = 1'b0;
    pre       = 1'b0;
    up        = 1'b0;
    wb        = 1'b0;
    base_code = 4'd0;
    stall     = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_vld", {31'd0, ldm_mem_vld}, 32'd0);
    chk("rst_wb_vld", {31'd0, ldm_wb_vld}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_offset", ldm_offset, 32'd0);
    chk("rst_reg_code", {28'd0, ldm_reg_code}, 32'd0);
    chk("rst_rd_code", {28'd0, rf_rd_code}, 32'd0);
    chk("rst_ldm_reg", ldm_reg, rf_data(4'd0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // LDMIA {R0-R3}
    push(4'd0, 32'd0,  1'b1, 1'b1, 1'b0);
    push(4'd1, 32'd4,  1'b1, 1'b1, 1'b0);
    push(4'd2, 32'd8,  1'b1, 1'b1, 1'b0);
    push(4'd3, 32'd12, 1'b1, 1'b1, 1'b1);
    run_seq("ldmia_f", 16'h000F, 1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 0, 1'b0, 5);

    // STMDB {R4,R14}, start held high one extra cycle
    push(4'd4,  32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
    push(4'd14, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
    run_seq("stmdb", 16'h4010, 1'b0, 1'b1, 1'b0, 1'b0, 4'd13, 0, 1'b1, 3);

    // LDMIB {R0,R15}, three stall cycles on beat 0
    push(4'd0,  32'd4, 1'b1, 1'b1, 1'b0);
    push(4'd15, 32'd8, 1'b1, 1'b1, 1'b1);
    run_seq("ldmib_stall", 16'h8001, 1'b1, 1'b1, 1'b1, 1'b0, 4'd13, 3, 1'b0, 6);

    // Empty list: single completion cycle
    push(4'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    run_seq("empty", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 0, 1'b0, 2);

    // STMIA {R5,R7}
    push(4'd5, 32'd0, 1'b1, 1'b0, 1'b0);
    push(4'd7, 32'd4, 1'b1, 1'b0, 1'b1);
    run_seq("stmia", 16'h00A0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd13, 0, 1'b0, 3);

    // LDMIA {R1,R2} with W=1, base R13
`ifdef LDM_BASE_WB_EN
    push(4'd1,  32'd0, 1'b1, 1'b1, 1'b0);
    push(4'd2,  32'd4, 1'b1, 1'b1, 1'b0);
    push(4'd13, 32'd8, 1'b0, 1'b1, 1'b1);
    run_seq("ldmia_wb", 16'h0006, 1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 0, 1'b0, 4);
`else
    push(4'd1, 32'd0, 1'b1, 1'b1, 1'b0);
    push(4'd2, 32'd4, 1'b1, 1'b1, 1'b1);
    run_seq("ldmia_wb", 16'h0006, 1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 0, 1'b0, 3);
`endif

    // STMDA {R1,R2} with W=1, base R5
`ifdef LDM_BASE_WB_EN
    push(4'd1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    push(4'd2, 32'd0,         1'b1, 1'b0, 1'b0);
    push(4'd5, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1);
    run_seq("stmda_wb", 16'h0006, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 0, 1'b0, 4);
`else
    push(4'd1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    push(4'd2, 32'd0,         1'b1, 1'b0, 1'b1);
    run_seq("stmda_wb", 16'h0006, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 0, 1'b0, 3);
`endif

    // LDMDA full list, reset while beat 5 is on the outputs
    push(4'd0, 32'hFFFF_FFC4, 1'b1, 1'b1, 1'b0);
    push(4'd1, 32'hFFFF_FFC8, 1'b1, 1'b1, 1'b0);
    push(4'd2, 32'hFFFF_FFCC, 1'b1, 1'b1, 1'b0);
    push(4'd3, 32'hFFFF_FFD0, 1'b1, 1'b1, 1'b0);
    push(4'd4, 32'hFFFF_FFD4, 1'b1, 1'b1, 1'b0);
    push(4'd5, 32'hFFFF_FFD8, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    start    = 1'b1;
    reg_list = 16'hFFFF;
    is_load  = 1'b1;
    pre      = 1'b0;
    up       = 1'b0;
    wb       = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_mem_vld", {31'd0, ldm_mem_vld}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_offset", ldm_offset, 32'd0);
    chk("abort_wb_vld", {31'd0, ldm_wb_vld}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_queue", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_stays_idle", {31'd0, ldm_mem_vld}, 32'd0);

    // Normal request after the abort
    push(4'd8, 32'd0, 1'b1, 1'b0, 1'b0);
    push(4'd9, 32'd4, 1'b1, 1'b0, 1'b1);
    run_seq("post_abort", 16'h0300, 1'b0, 1'b0, 1'b1, 1'b0, 4'd13, 0, 1'b0, 3);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
